// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter between instruction fetch and data memory.
// Data requests have priority. A starvation counter forces a fetch grant after
// STARVE_LIMIT consecutive data grants while a fetch is pending.
// Optional feature macro: ARB_TIMEOUT_EN adds a busy-state timeout and the
// timeout_err output.
module mem_arbiter #(
  parameter int unsigned WORD_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate
`ifdef ARB_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  typedef enum logic [2:0] {IDLE, IBUSY, DBUSY, IDONE, DDONE} state_t;
  typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ramstate_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t     state, state_next;
  ramstate_t  ram_st;
  logic [3:0] starve_cnt;
  logic       grant_d, grant_i, ram_done, busy_end, timeout_hit;

  assign ram_st   = ramstate_t'(ramstate);
  assign ram_done = (ram_st == RAM_ACCESS) || (ram_st == RAM_ERROR);

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
  logic [CNT_W-1:0] busy_cnt;
  assign timeout_hit = (busy_cnt == CNT_W'(TIMEOUT - 1)) && !ram_done;

  // Busy-cycle counter: zero while idle so it starts fresh on every grant.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      busy_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= (state == IBUSY || state == DBUSY) && timeout_hit;
      if (state == IBUSY || state == DBUSY)
        busy_cnt <= busy_cnt + 1'b1;
      else
        busy_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign busy_end = ram_done || timeout_hit;

  // Arbitration decision, only acted upon in IDLE.
  always_comb begin
    grant_d = (dREN || dWEN) && !(iREN && (starve_cnt == STARVE_MAX));
    grant_i = !grant_d && iREN;
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and wait strobes.
  always_comb begin
    state_next = state;
    iwait      = 1'b1;
    dwait      = 1'b1;
    case (state)
      IDLE: begin
        if (grant_d)      state_next = DBUSY;
        else if (grant_i) state_next = IBUSY;
      end
      IBUSY: if (busy_end) state_next = IDONE;
      DBUSY: if (busy_end) state_next = DDONE;
      IDONE: begin
        iwait      = 1'b0;
        state_next = IDLE;
      end
      DDONE: begin
        dwait      = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // RAM request registers, load capture and starvation counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ramREN     <= 1'b0;
      ramWEN     <= 1'b0;
      ramaddr    <= '0;
      ramstore   <= '0;
      iload      <= '0;
      dload      <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            ramaddr  <= daddr;
            ramstore <= dstore;
            ramWEN   <= dWEN;
            ramREN   <= !dWEN;
            if (!iREN)
              starve_cnt <= '0;
            else if (starve_cnt != STARVE_MAX)
              starve_cnt <= starve_cnt + 4'd1;
          end else if (grant_i) begin
            ramaddr    <= iaddr;
            ramREN     <= 1'b1;
            ramWEN     <= 1'b0;
            starve_cnt <= '0;
          end else begin
            // No grant here implies iREN=0.
            starve_cnt <= '0;
          end
        end
        IBUSY: begin
          if (busy_end) begin
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            iload  <= timeout_hit ? '0 : ramload;
          end
        end
        DBUSY: begin
          if (busy_end) begin
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            dload  <= timeout_hit ? '0 : ramload;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
